// File: rtl/sym_fir_pkg.sv
// Shared constants, types and default coefficients for the time-multiplexed symmetric FIR.
// Latency: n/a (package only).
// Backpressure: n/a.
package sym_fir_pkg;

    localparam int DATA_W = 18;
    localparam int COEF_W = 18;
    localparam int N_UNIQ = 11;
    localparam int N_TAPS = 2 * N_UNIQ - 1;
    localparam int ACC_W  = 40;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int K_W    = 4;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [DATA_W-1:0] samp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Power-up sine-shaping coefficients, b0 (outer taps) .. b10 (centre tap).
    localparam coef_t DEF_COEF [N_UNIQ] = '{
        18'sd4091,   18'sd5895,   18'sd3323,  -18'sd3445,
       -18'sd10669, -18'sd12449, -18'sd4024,   18'sd14901,
        18'sd38953,  18'sd59086,  18'sd66926
    };

endpackage

// File: rtl/sym_fir_coef_bank.sv
// Double-buffered coefficient store: shadow written any time, copied atomically into active when idle.
// Latency: write/swap take effect on the next edge; read by index is combinational.
// Backpressure: none; a commit outside IDLE is held as swap_pending until the sequencer idles.
module sym_fir_coef_bank
    import sym_fir_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           we,
    input  logic [K_W-1:0] addr,
    input  coef_t          wdata,
    input  logic           commit,
    input  logic           idle,
    input  logic [K_W-1:0] rd_idx,
    output coef_t          rd_coef,
    output logic           swap_pending
);

    coef_t shadow     [N_UNIQ];
    coef_t active     [N_UNIQ];
    coef_t shadow_nxt [N_UNIQ];
    logic  swap;

    // Shadow contents after this cycle's write; the swap copies this so a same-cycle write is included.
    always_comb begin
        for (int i = 0; i < N_UNIQ; i++) begin
            shadow_nxt[i] = shadow[i];
            if (we && (addr == K_W'(i))) begin
                shadow_nxt[i] = wdata;
            end
        end
    end

    // Active bank only changes while the sequencer is idle, so a running sum never mixes banks.
    assign swap = idle && (swap_pending || commit);

    // Bank registers and pending-swap flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_UNIQ; i++) begin
                shadow[i] <= DEF_COEF[i];
                active[i] <= DEF_COEF[i];
            end
            swap_pending <= 1'b0;
        end else begin
            for (int i = 0; i < N_UNIQ; i++) begin
                shadow[i] <= shadow_nxt[i];
                if (swap) begin
                    active[i] <= shadow_nxt[i];
                end
            end
            swap_pending <= swap ? 1'b0 : (swap_pending | commit);
        end
    end

    // Coefficient lookup for the current step; out-of-range index reads zero.
    always_comb begin
        rd_coef = '0;
        for (int i = 0; i < N_UNIQ; i++) begin
            if (rd_idx == K_W'(i)) begin
                rd_coef = active[i];
            end
        end
    end

endmodule

// File: rtl/sym_fir_seq_ctrl.sv
// 21-tap symmetric FIR sequenced over 11 unique coefficients with one pre-adder, multiplier and accumulator.
// Latency: sam_en at edge t0 -> y/y_valid updated at edge t12; minimum sample period 13 clocks.
// Backpressure: none; a sam_en while busy is dropped and sets sticky overrun. Optional SYM_FIR_SAT_EN saturates y.
module sym_fir_seq_ctrl
    import sym_fir_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              sam_en,
    input  logic [DATA_W-1:0] x_in,
    input  logic              coef_we,
    input  logic [K_W-1:0]    coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    input  logic              coef_commit,
    output logic              busy,
    output logic [DATA_W-1:0] y,
    output logic              y_valid,
    output logic              overrun,
    output logic              swap_pending
);

    state_t                    state;
    state_t                    state_nxt;
    samp_t                     xd [N_TAPS];
    samp_t                     x_scaled;
    samp_t                     pre;
    coef_t                     coef_k;
    logic signed [PROD_W-1:0]  prod;
    logic        [ACC_W-1:0]   acc;
    logic        [K_W-1:0]     k;
    logic        [DATA_W-1:0]  y_calc;

    sym_fir_coef_bank u_bank (
        .clk          (clk),
        .reset        (reset),
        .we           (coef_we),
        .addr         (coef_addr),
        .wdata        (coef_data),
        .commit       (coef_commit),
        .idle         (state == IDLE),
        .rd_idx       (k),
        .rd_coef      (coef_k),
        .swap_pending (swap_pending)
    );

    // Halve the input (1s17 -> 2s16) so a pre-add of two taps always fits in 18 bits.
    assign x_scaled = $signed(x_in) >>> 1;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and busy decode.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (sam_en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (k == K_W'(N_UNIQ - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pre-adder folds the mirrored tap pair for step k; the centre tap stands alone.
    always_comb begin
        pre = xd[N_UNIQ-1];
        for (int i = 0; i < N_UNIQ - 1; i++) begin
            if (k == K_W'(i)) begin
                pre = xd[i] + xd[N_TAPS-1-i];
            end
        end
    end

    assign prod = pre * coef_k;

    // Delay line shift on accepted samples; accumulate one coefficient per RUN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_TAPS; i++) begin
                xd[i] <= '0;
            end
            acc <= '0;
            k   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sam_en) begin
                        xd[0] <= x_scaled;
                        for (int i = 1; i < N_TAPS; i++) begin
                            xd[i] <= xd[i-1];
                        end
                        acc <= '0;
                        k   <= '0;
                    end
                end
                RUN: begin
                    acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
                    k   <= k + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Output formatting: drop 17 fractional bits (floor), optionally clamp to the 18-bit range.
`ifdef SYM_FIR_SAT_EN
    logic [ACC_W-35:0] acc_top;
    assign acc_top = acc[ACC_W-1:34];

    always_comb begin
        y_calc = acc[34:17];
        if (!((&acc_top) || !(|acc_top))) begin
            y_calc = acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    always_comb begin
        y_calc = acc[34:17];
    end
`endif

    // Registered result, one-cycle valid pulse and sticky overrun flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y       <= '0;
            y_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            y_valid <= (state == DONE);
            if (state == DONE) begin
                y <= y_calc;
            end
            if (sam_en && busy) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sym_fir_seq_ctrl.sv
// Self-checking bench for sym_fir_seq_ctrl: impulse table, DC, overrun, coefficient swaps, saturation, mid-run reset.
// Expected outputs come from hand constants or a direct 21-tap reference sum, held in a scoreboard queue.
// Outputs are sampled on the falling edge; inputs change one time unit after the rising edge.
module tb_sym_fir_seq_ctrl;

    typedef logic signed [17:0] s18_t;

    typedef struct {
        logic [17:0] x;
        s18_t        y;
    } vec_t;

    typedef struct {
        s18_t y;
        int   cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sam_en = 1'b0;
    logic [17:0] x_in = '0;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [17:0] coef_data = '0;
    logic        coef_commit = 1'b0;
    logic        busy;
    logic [17:0] y;
    logic        y_valid;
    logic        overrun;
    logic        swap_pending;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    exp_t exp_q [$];
    vec_t tbl [23];
    int   imp_y [23] = '{2045, 2947, 1661, -1723, -5335, -6225, -2012, 7450, 19476, 29542, 33462,
                         29542, 19476, 7450, -2012, -6225, -5335, -1723, 1661, 2947, 2045, 0, 0};
    int   def_c [11] = '{4091, 5895, 3323, -3445, -10669, -12449, -4024, 14901, 38953, 59086, 66926};

    s18_t m_x [21];
    s18_t m_shadow [11];
    s18_t m_active [11];
    bit   m_pending;
    bit   m_overrun;
    int   last_c;

    sym_fir_seq_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .sam_en       (sam_en),
        .x_in         (x_in),
        .coef_we      (coef_we),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .coef_commit  (coef_commit),
        .busy         (busy),
        .y            (y),
        .y_valid      (y_valid),
        .overrun      (overrun),
        .swap_pending (swap_pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic s18_t model_y(input longint acc);
        longint hi;
        hi = acc >>> 17;
`ifdef SYM_FIR_SAT_EN
        if (hi > 131071) return 18'sd131071;
        if (hi < -131072) return $signed(18'h20000);
`endif
        return hi[17:0];
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 21; i++) m_x[i] = '0;
        for (int i = 0; i < 11; i++) begin
            m_shadow[i] = s18_t'(def_c[i]);
            m_active[i] = s18_t'(def_c[i]);
        end
        m_pending = 1'b0;
        m_overrun = 1'b0;
        last_c    = -1000;
    endtask

    // One clock of stimulus; the reference model tracks acceptance, banks and flags alongside.
    task automatic step(input bit sam, input logic [17:0] x, input bit we, input logic [3:0] addr,
                        input logic [17:0] data, input bit commit, input bit use_ov, input s18_t ov);
        int     c;
        bit     idle_now;
        bit     busy_exp;
        longint acc;
        exp_t   e;
        c = cyc;
        sam_en = sam; x_in = x; coef_we = we; coef_addr = addr; coef_data = data; coef_commit = commit;
        idle_now = (c >= last_c + 13);
        if (we && addr <= 4'd10) m_shadow[addr] = data;
        if (commit) m_pending = 1'b1;
        if (idle_now && m_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        if (sam) begin
            if (idle_now) begin
                for (int i = 20; i > 0; i--) m_x[i] = m_x[i-1];
                m_x[0] = $signed(x) >>> 1;
                acc = 0;
                for (int i = 0; i < 21; i++) begin
                    acc += longint'(m_x[i]) * longint'(m_active[(i <= 10) ? i : 20 - i]);
                end
                e.y   = use_ov ? ov : model_y(acc);
                e.cyc = c + 13;
                exp_q.push_back(e);
                last_c = c;
            end else begin
                m_overrun = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        sam_en = 1'b0; coef_we = 1'b0; coef_commit = 1'b0; x_in = '0; coef_addr = '0; coef_data = '0;
        @(negedge clk);
        busy_exp = (c >= last_c) && (c <= last_c + 11);
        chk("busy", busy, busy_exp);
        chk("swap_pending", swap_pending, m_pending);
        chk("overrun", overrun, m_overrun);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, '0, 0, 0, '0);
    endtask

    task automatic send(input logic [17:0] x);
        step(1, x, 0, '0, '0, 0, 0, '0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (y_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("y_valid_unexpected", y_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("y", $signed(y), e.y);
                    chk("y_valid_cycle", cyc, e.cyc);
                end
            end
            if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                chk("y_valid_missing", y_valid, 1);
                e = exp_q.pop_front();
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 23; i++) begin
            tbl[i].x = (i == 0) ? 18'd131071 : 18'd0;
            tbl[i].y = s18_t'(imp_y[i]);
        end
        model_reset();

        // Reset values, checked while reset is held.
        repeat (3) @(negedge clk);
        chk("rst_y", y, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_swap_pending", swap_pending, 0);
        reset = 1'b0;
        @(negedge clk);
        fork
            monitor();
        join_none

        // Impulse response against hand-computed constants, one sample every 16 clocks.
        for (int i = 0; i < 23; i++) begin
            step(1, tbl[i].x, 0, '0, '0, 0, 1, tbl[i].y);
            idle(15);
        end

        // DC at full scale, back-to-back at the minimum 13-clock period.
        for (int i = 0; i < 25; i++) begin
            send(18'd131071);
            idle(12);
        end

        // Overrun: second strobe 5 clocks in is dropped; overrun sticks.
        send(18'd1000);
        idle(4);
        send(18'd5000);
        idle(7);
        send(18'd3000);
        idle(12);

        // Mid-run commit: current output keeps the old bank, the next uses the new one.
        for (int a = 0; a < 10; a++) step(0, '0, 1, 4'(a), 18'd0, 0, 0, '0);
        step(0, '0, 1, 4'd10, 18'd131071, 0, 0, '0);
        step(0, '0, 1, 4'd11, 18'd12345, 0, 0, '0);
        send(18'd40000);
        idle(2);
        step(0, '0, 0, '0, '0, 1, 0, '0);
        idle(10);
        send(18'd77777);
        idle(12);

        // Write and commit in the same idle cycle, then sample + write + commit on one edge.
        step(0, '0, 1, 4'd3, 18'd20000, 1, 0, '0);
        idle(1);
        step(1, 18'h30000, 1, 4'd5, 18'h3F000, 1, 0, '0);
        idle(12);
        send(18'd1234);
        idle(12);

        // Saturation: all coefficients at full scale with a full-scale DC input.
        for (int a = 0; a < 11; a++) step(0, '0, 1, 4'(a), 18'd131071, 0, 0, '0);
        step(0, '0, 0, '0, '0, 1, 0, '0);
        for (int i = 0; i < 21; i++) begin
            send(18'd131071);
            idle(12);
        end

        // Reset in the middle of a run with a commit pending.
        send(18'd50000);
        idle(2);
        step(0, '0, 0, '0, '0, 1, 0, '0);
        idle(2);
        reset = 1'b1;
        #1;
        model_reset();
        chk("midrst_y", y, 0);
        chk("midrst_y_valid", y_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_swap_pending", swap_pending, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        step(1, 18'd131071, 0, '0, '0, 0, 1, 18'sd2045);
        idle(12);
        send(18'd0);
        idle(12);
        idle(20);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
